// File: rtl/riscv_div_seq.sv
// riscv_div_seq: iterative RV32M DIV/DIVU/REM/REMU unit for the execute stage.
// It produces one quotient bit per cycle using restoring shift-subtract, and
// resolves divide-by-zero and signed overflow at accept time. It stalls the
// front of the pipe while computing, then returns the result as a one-cycle
// o_valid pulse.
module riscv_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rem_sel_q, rem_sel_d;   // 1: return remainder
  logic            neg_quot_q, neg_quot_d; // quotient needs negation
  logic            neg_rem_q, neg_rem_d;   // remainder needs negation
  logic [XLEN-1:0] quot_q, quot_d;         // magnitude of dividend, shifted into quotient
  logic [XLEN-1:0] rem_q, rem_d;           // partial remainder
  logic [XLEN-1:0] divisor_q, divisor_d;   // magnitude of divisor
  logic [XLEN-1:0] result_q, result_d;

  // Accept-time decode of the incoming operation
  logic            accept;
  logic            is_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] special_result;

  // One restoring iteration
  logic [XLEN-1:0] rem_shift;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_step, quot_step;
  logic [XLEN-1:0] quot_fin, rem_fin, res_fin;
  logic            last_iter;

  assign accept    = (state_q == S_IDLE) & i_start & i_funct3[2] & ~i_flush;
  assign is_signed = ~i_funct3[0];
  assign a_neg     = is_signed & i_dividend[XLEN-1];
  assign b_neg     = is_signed & i_divisor[XLEN-1];
  assign a_abs     = a_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign b_abs     = b_neg ? (~i_divisor + 1'b1) : i_divisor;
  assign div_zero  = (i_divisor == '0);
  assign overflow  = is_signed & (i_dividend == MIN_NEG) & (&i_divisor);
  assign special   = div_zero | overflow;
  // Special-case results are final values: no sign correction applies.
  assign special_result = div_zero ? (i_funct3[1] ? i_dividend : '1)
                                   : (i_funct3[1] ? '0 : MIN_NEG);

  // The shifted-out MSB of rem_q acts as the 33rd bit of the partial
  // remainder, so divisors >= 2^(XLEN-1) compare correctly with an
  // XLEN+1-bit subtractor. When that bit is set the remainder is certainly
  // >= divisor and the low XLEN bits of diff are the exact difference.
  assign rem_shift = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
  assign diff      = {1'b0, rem_shift} - {1'b0, divisor_q};
  assign ge        = rem_q[XLEN-1] | ~diff[XLEN];
  assign rem_step  = ge ? diff[XLEN-1:0] : rem_shift;
  assign quot_step = {quot_q[XLEN-2:0], ge};
  assign last_iter = (cnt_q == CW'(XLEN-1));

  assign quot_fin = neg_quot_q ? (~quot_step + 1'b1) : quot_step;
  assign rem_fin  = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
  assign res_fin  = rem_sel_q ? rem_fin : quot_fin;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (last_iter) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  // Outputs: busy stalls F/D/E; valid pulses only in an unflushed DONE
  always_comb begin
    o_busy   = accept | ((state_q == S_CALC) & ~i_flush);
    o_valid  = (state_q == S_DONE) & ~i_flush;
    o_result = result_q;
  end

  // Datapath next-state: load on accept, iterate in CALC, result on last step
  always_comb begin
    cnt_d      = cnt_q;
    rem_sel_d  = rem_sel_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    if (i_flush) begin
      cnt_d      = '0;
      rem_sel_d  = 1'b0;
      neg_quot_d = 1'b0;
      neg_rem_d  = 1'b0;
      quot_d     = '0;
      rem_d      = '0;
      divisor_d  = '0;
    end else if (accept) begin
      cnt_d      = '0;
      rem_sel_d  = i_funct3[1];
      neg_quot_d = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      quot_d     = a_abs;
      rem_d      = '0;
      divisor_d  = b_abs;
      if (special) result_d = special_result;
    end else if (state_q == S_CALC) begin
      cnt_d  = cnt_q + CW'(1);
      quot_d = quot_step;
      rem_d  = rem_step;
      if (last_iter) result_d = res_fin;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= '0;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rem_sel_q  <= rem_sel_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_riscv_div_seq.sv
// Testbench for riscv_div_seq: a driver issues operations and checks o_busy
// cycle by cycle, while a monitor pops expected results from a scoreboard
// whenever o_valid pulses.
module tb_riscv_div_seq;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_dividend, i_divisor;
  logic        o_busy, o_valid;
  logic [31:0] o_result;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
  } exp_t;
  exp_t scb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_div_seq #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_funct3(i_funct3),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_flush(i_flush),
    .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result)
  );

  // Reference: RISC-V M semantics via 64-bit arithmetic (C-style truncation).
  function automatic logic [31:0] ref_div(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      n_vec++;
      if (scb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid cyc=%0d got result=%h required no valid", cyc, o_result);
      end else begin
        e = scb.pop_front();
        if (o_result !== e.res || cyc != e.due) begin
          n_bad++;
          $display("FAIL result cyc=%0d got=%h required=%h at cyc=%0d",
                   cyc, o_result, e.res, e.due);
        end else begin
          $display("result cyc=%0d res=%h ok", cyc, o_result);
        end
      end
    end
  end

  // Issue one op (start held through DONE, as execute would); flush_k >= 0
  // flushes that many cycles after accept. Operand buses are scrambled after
  // accept to confirm they are latched.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int flush_k);
    int          lat;
    logic        sp;
    exp_t        e;
    sp  = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    lat = sp ? 1 : 33;
    i_start = 1'b1; i_funct3 = f3; i_dividend = a; i_divisor = b;
    $display("issue cyc=%0d f3=%b a=%h b=%h flush_k=%0d", cyc, f3, a, b, flush_k);
    if (flush_k < 0) begin
      e.res = ref_div(f3, a, b);
      e.due = cyc + lat;
      scb.push_back(e);
    end
    for (int k = 0; k <= lat; k++) begin
      if (k == flush_k) i_flush = 1'b1;
      @(negedge clk);
      chk("busy", {31'd0, o_busy}, {31'd0, (k < lat) && (k != flush_k)});
      @(posedge clk); #1;
      i_dividend = $urandom; i_divisor = $urandom;
      if (k == flush_k) begin
        i_flush = 1'b0;
        break;
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          mode, fk;

    i_rst = 1'b1; i_start = 1'b0; i_flush = 1'b0;
    i_funct3 = 3'b000; i_dividend = '0; i_divisor = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    @(posedge clk); #1;

    // Directed cases
    do_op(3'b101, 32'd100, 32'd7, -1);
    do_op(3'b111, 32'd100, 32'd7, -1);
    do_op(3'b100, -32'sd7, 32'd2, -1);
    do_op(3'b110, -32'sd7, 32'd2, -1);
    do_op(3'b110, 32'd7, -32'sd2, -1);
    do_op(3'b101, 32'h1234, 32'd0, -1);
    do_op(3'b110, 32'h1234, 32'd0, -1);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, -1);

    // Flush mid-CALC, then a fresh op one idle cycle later
    do_op(3'b101, 32'd1000, 32'd7, 10);
    @(posedge clk); #1;
    do_op(3'b101, 32'd9, 32'd3, -1);

    // Non-divide funct3 must not be accepted
    i_start = 1'b1; i_funct3 = 3'b000; i_dividend = 32'd50; i_divisor = 32'd5;
    @(negedge clk);
    chk("nondiv_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1 i_start = 1'b0;

    // Reset mid-CALC aborts with no result
    i_start = 1'b1; i_funct3 = 3'b101; i_dividend = 32'd1000; i_divisor = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      f3   = 3'(4 + $urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = b | 32'h8000_0000;
        4: b = $urandom_range(1, 255);
        default: ;
      endcase
      fk = -1;
      if (b != 32'd0 && mode != 1 && $urandom_range(0, 9) == 0)
        fk = $urandom_range(1, 32);
      do_op(f3, a, b, fk);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", scb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_div_seq.md
# riscv_div_seq

Iterative RV32M divide/remainder sequencer attached to the execute stage of the pipelined core. It accepts one DIV/DIVU/REM/REMU operation from execute, using the post-forwarding operands. While it computes, it stalls fetch/decode/execute through the hazard unit. It returns the result as a one-cycle valid pulse in the cycle execute is released. It runs a restoring shift-subtract loop, one quotient bit per cycle, and handles divide-by-zero and signed overflow without iterating.

## Interface
- XLEN, 32, operand/result width
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_start  input  1  execute holds a divide-class instruction (funct3[2]=1, M-ext opcode); sampled only in IDLE
- i_funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; start ignored if bit2=0
- i_dividend  input  XLEN  forwarded SrcA
- i_divisor  input  XLEN  forwarded SrcB
- i_flush  input  1  execute-stage flush; aborts any operation
- o_busy  output  1  stall request to hazard unit (F/D/E hold)
- o_valid  output  1  one-cycle pulse, o_result valid
- o_result  output  XLEN  quotient or remainder, registered

## Operation
- States: IDLE, CALC, DONE.
- IDLE: when i_start & i_funct3[2] & !i_flush, latch funct3, operand signs, |dividend|, |divisor|.
  - Absolute value is taken only for DIV/REM.
  - Next state is DONE for the special cases below; otherwise CALC with counter=0.
- Special cases, resolved at accept with no iteration:
  - divisor=0: quotient = all ones; remainder = dividend.
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC, one iteration per cycle:
  - rem = {rem[XLEN-2:0], q[XLEN-1]}; q <<= 1.
  - If rem ≥ divisor: rem -= divisor; q[0] = 1.
  - Use an XLEN+1-bit subtractor for the compare.
  - Counter increments each cycle. When counter = XLEN-1, next state is DONE.
- DONE:
  - o_result = quotient (funct3[1]=0) or remainder (funct3[1]=1).
  - Sign correction, signed ops only: quotient is negated when sign(a) XOR sign(b); remainder takes sign(a).
  - o_valid=1 for this cycle only; next state IDLE.
  - i_start is ignored in DONE, because the same instruction is still in execute.
- o_busy is combinational: (IDLE & i_start & funct3[2] & !i_flush) | CALC. It is low in DONE so execute advances with the result.
- i_flush in any state: next state IDLE, no o_valid, o_busy low that cycle, latched operands discarded. Flush has priority over start.
- o_result holds its last value outside DONE; consumers qualify it with o_valid.
- Reset: state IDLE, counter 0, o_busy 0, o_valid 0, o_result 0, internal registers 0. Reset during CALC or DONE aborts with no o_valid.

## Timing
- Accept at cycle T (IDLE, o_busy=1 combinationally).
- Normal operation: CALC T+1..T+XLEN, DONE at T+XLEN+1.
  - o_valid at T+33 for XLEN=32.
  - o_busy high T..T+32.
- Special cases: DONE at T+1, o_valid at T+1, o_busy high only at T.
- Back-to-back: the earliest next accept is the cycle after DONE, when the new instruction is in execute.
- Throughput: one op per XLEN+2 cycles.
- No combinational path from i_dividend or i_divisor to any output. o_busy depends only on state, i_start, i_funct3 and i_flush.

## Test plan
- DIVU 100/7 at T: o_busy high T..T+32, o_valid T+33 with o_result=14. REMU same operands gives 2.
- Signed: DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); REM 7/-2 gives 1. All at T+33.
- Divide-by-zero: DIVU 0x1234/0 gives 0xFFFFFFFF at T+1; REM 0x1234/0 gives 0x1234 at T+1; o_busy high only at T.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0. Both at T+1.
- Flush at T+10 during CALC: o_busy low at T+10, state IDLE at T+11, no o_valid ever. A fresh DIVU 9/3 accepted at T+12 yields 3 at T+45.
- i_rst asserted at T+5 mid-CALC: at T+6 o_busy=0, o_valid=0, o_result=0. Start held high through DONE is not re-accepted; exactly one o_valid per operation.
